// File: rtl/pueo_trig_sched.sv
// Trigger scheduler: queues trigger times stamped with event numbers, gates them with a
// run/drain state machine and spaces readout requests by a programmable holdoff.
// Optional drop counter output enabled by `define PUEO_TRIG_SCHED_DROPCNT_EN.
module pueo_trig_sched #(
    parameter int TIME_BITS       = 16,
    parameter int EVNUM_BITS      = 16,
    parameter int DEPTH_LOG2      = 4,
    parameter int HOLDOFF_BITS    = 24,
    parameter int HOLDOFF_DEFAULT = 20475
) (
    input  logic                             aclk_i,
    input  logic                             aresetn_i,
    input  logic                             run_rst_i,
    input  logic                             run_stop_i,
    input  logic [HOLDOFF_BITS-1:0]          holdoff_i,
    input  logic [TIME_BITS-1:0]             trig_time_i,
    input  logic                             trig_valid_i,
    output logic [EVNUM_BITS+TIME_BITS-1:0]  m_tdata,
    output logic                             m_tvalid,
    input  logic                             m_tready,
    output logic                             running_o,
    output logic [DEPTH_LOG2:0]              pending_o,
    output logic                             overflow_o,
    output logic                             stop_done_o
`ifdef PUEO_TRIG_SCHED_DROPCNT_EN
    ,
    output logic [15:0]                      drop_count_o
`endif
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int W     = EVNUM_BITS + TIME_BITS;
    localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_t;

    state_t                  state_q;
    logic [W-1:0]            mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]     count_q, count_d;
    logic [EVNUM_BITS-1:0]   evnum_q;
    logic [HOLDOFF_BITS-1:0] holdoff_q, timer_q, timer_d;
    logic [W-1:0]            tdata_q, head_d, push_entry;
    logic                    tvalid_q, running_q, overflow_q, stop_done_q;
    logic                    trig_ok, full, pop, push, drop;

    always_comb begin
        trig_ok    = (state_q == ST_RUN) && trig_valid_i && !run_rst_i;
        full       = (count_q == FULL_CNT);
        pop        = tvalid_q && m_tready;
        push       = trig_ok && (!full || pop);
        drop       = trig_ok && full && !pop;
        push_entry = {evnum_q, trig_time_i};
        rd_ptr_d   = rd_ptr_q + DEPTH_LOG2'(pop);
        wr_ptr_d   = wr_ptr_q + DEPTH_LOG2'(push);
        count_d    = count_q + (DEPTH_LOG2+1)'(push) - (DEPTH_LOG2+1)'(pop);
        // A push into a queue that is (or becomes) empty has not reached memory yet: bypass it.
        if ((count_q == '0) || (pop && count_q == (DEPTH_LOG2+1)'(1)))
            head_d = push_entry;
        else
            head_d = mem_q[rd_ptr_d];
        timer_d = timer_q;
        if (pop)
            timer_d = holdoff_q;
        else if (timer_q != '0)
            timer_d = timer_q - HOLDOFF_BITS'(1);
    end

    always_ff @(posedge aclk_i) begin
        if (push)
            mem_q[wr_ptr_q] <= push_entry;
    end

    always_ff @(posedge aclk_i) begin
        if (!aresetn_i) begin
            state_q     <= ST_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            evnum_q     <= '0;
            timer_q     <= '0;
            holdoff_q   <= HOLDOFF_BITS'(HOLDOFF_DEFAULT);
            tdata_q     <= '0;
            tvalid_q    <= 1'b0;
            running_q   <= 1'b0;
            overflow_q  <= 1'b0;
            stop_done_q <= 1'b0;
        end else if (run_rst_i) begin
            state_q     <= ST_RUN;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            evnum_q     <= '0;
            timer_q     <= '0;
            holdoff_q   <= holdoff_i;
            tdata_q     <= '0;
            tvalid_q    <= 1'b0;
            running_q   <= 1'b1;
            overflow_q  <= 1'b0;
            stop_done_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            timer_q     <= timer_d;
            tvalid_q    <= (count_d != '0) && (timer_d == '0);
            stop_done_q <= 1'b0;
            if (count_d != '0)
                tdata_q <= head_d;
            // Dropped triggers still consume an event number so losses show as gaps.
            if (trig_ok)
                evnum_q <= evnum_q + EVNUM_BITS'(1);
            if (drop)
                overflow_q <= 1'b1;
            case (state_q)
                ST_RUN: begin
                    if (run_stop_i) begin
                        state_q   <= ST_DRAIN;
                        running_q <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    if (count_q == '0 && timer_q == '0) begin
                        state_q     <= ST_IDLE;
                        stop_done_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef PUEO_TRIG_SCHED_DROPCNT_EN
    logic [15:0] drop_cnt_q;

    always_ff @(posedge aclk_i) begin
        if (!aresetn_i || run_rst_i)
            drop_cnt_q <= '0;
        else if (drop && drop_cnt_q != 16'hFFFF)
            drop_cnt_q <= drop_cnt_q + 16'd1;
    end

    assign drop_count_o = drop_cnt_q;
`endif

    assign m_tdata     = tdata_q;
    assign m_tvalid    = tvalid_q;
    assign running_o   = running_q;
    assign pending_o   = count_q;
    assign overflow_o  = overflow_q;
    assign stop_done_o = stop_done_q;

endmodule

// File: tb/tb_pueo_trig_sched.sv
// Directed self-checking bench for pueo_trig_sched (queue depth 4, 16-bit time/event fields).
module tb_pueo_trig_sched;

    logic        clk = 1'b0;
    logic        aresetn, run_rst, run_stop, trig_valid, m_tready;
    logic [23:0] holdoff;
    logic [15:0] trig_time;
    logic [31:0] m_tdata;
    logic        m_tvalid, running, overflow, stop_done;
    logic [2:0]  pending;
`ifdef PUEO_TRIG_SCHED_DROPCNT_EN
    logic [15:0] drop_count;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pueo_trig_sched #(.DEPTH_LOG2(2)) dut (
        .aclk_i(clk), .aresetn_i(aresetn), .run_rst_i(run_rst), .run_stop_i(run_stop),
        .holdoff_i(holdoff), .trig_time_i(trig_time), .trig_valid_i(trig_valid),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
        .running_o(running), .pending_o(pending), .overflow_o(overflow),
        .stop_done_o(stop_done)
`ifdef PUEO_TRIG_SCHED_DROPCNT_EN
        , .drop_count_o(drop_count)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input logic [23:0] h);
        run_rst = 1'b1; holdoff = h;
        tick();
        run_rst = 1'b0;
    endtask

    task automatic test_reset();
        aresetn = 1'b0; run_rst = 1'b0; run_stop = 1'b0; trig_valid = 1'b0;
        m_tready = 1'b0; holdoff = '0; trig_time = '0;
        tick(); tick();
        aresetn = 1'b1;
        checks++;
        if ({m_tvalid, running, overflow, stop_done} !== 4'b0000) begin
            errors++; $display("FAIL reset_flags: got %b want 0000", {m_tvalid, running, overflow, stop_done});
        end
        checks++;
        if (pending !== 3'd0 || m_tdata !== 32'd0) begin
            errors++; $display("FAIL reset_queue: pending %0d tdata %h want 0/0", pending, m_tdata);
        end
        // Idle trigger must be ignored.
        trig_valid = 1'b1; trig_time = 16'h0BAD;
        tick();
        trig_valid = 1'b0;
        tick();
        checks++;
        if (m_tvalid !== 1'b0 || pending !== 3'd0) begin
            errors++; $display("FAIL reset_idle_trig: valid %b pending %0d want 0/0", m_tvalid, pending);
        end
    endtask

    task automatic test_basic();
        logic [31:0] exp [3];
        exp[0] = {16'd0, 16'h0010}; exp[1] = {16'd1, 16'h0020}; exp[2] = {16'd2, 16'h0030};
        start_run(24'd0);
        checks++;
        if (running !== 1'b1 || m_tvalid !== 1'b0) begin
            errors++; $display("FAIL basic_start: running %b valid %b want 1/0", running, m_tvalid);
        end
        m_tready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            trig_valid = 1'b1; trig_time = 16'h0010 * 16'(i + 1);
            tick();
            checks++;
            if (m_tvalid !== 1'b1 || m_tdata !== exp[i]) begin
                errors++; $display("FAIL basic_hs%0d: valid %b tdata %h want 1 %h", i, m_tvalid, m_tdata, exp[i]);
            end
        end
        trig_valid = 1'b0;
        tick();
        checks++;
        if (m_tvalid !== 1'b0 || pending !== 3'd0) begin
            errors++; $display("FAIL basic_empty: valid %b pending %0d want 0/0", m_tvalid, pending);
        end
    endtask

    task automatic test_holdoff();
        int n;
        start_run(24'd5);
        m_tready = 1'b1;
        trig_valid = 1'b1; trig_time = 16'h000A;
        tick();
        checks++;
        if (m_tvalid !== 1'b1 || m_tdata !== {16'd0, 16'h000A}) begin
            errors++; $display("FAIL holdoff_first: valid %b tdata %h want 1 %h", m_tvalid, m_tdata, {16'd0, 16'h000A});
        end
        trig_time = 16'h000B;
        tick();  // first handshake here, second trigger queued
        trig_valid = 1'b0;
        n = 0;
        while (m_tvalid !== 1'b1 && n < 20) begin
            tick(); n++;
        end
        // valid after 5 more edges -> handshake on the 6th edge after the first
        checks++;
        if (n !== 5) begin
            errors++; $display("FAIL holdoff_gap: got %0d idle edges want 5", n);
        end
        checks++;
        if (m_tdata !== {16'd1, 16'h000B}) begin
            errors++; $display("FAIL holdoff_second: tdata %h want %h", m_tdata, {16'd1, 16'h000B});
        end
        tick();
        checks++;
        if (m_tvalid !== 1'b0) begin
            errors++; $display("FAIL holdoff_after: valid %b want 0", m_tvalid);
        end
    endtask

    task automatic test_overflow();
        start_run(24'd0);
        m_tready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            trig_valid = 1'b1; trig_time = 16'h0100 + 16'(i);
            tick();
        end
        trig_valid = 1'b0;
        checks++;
        if (pending !== 3'd4 || overflow !== 1'b1) begin
            errors++; $display("FAIL ovf_full: pending %0d overflow %b want 4/1", pending, overflow);
        end
`ifdef PUEO_TRIG_SCHED_DROPCNT_EN
        checks++;
        if (drop_count !== 16'd2) begin
            errors++; $display("FAIL ovf_dropcnt: got %0d want 2", drop_count);
        end
`endif
        m_tready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (m_tvalid !== 1'b1 || m_tdata !== {16'(i), 16'h0100 + 16'(i)}) begin
                errors++; $display("FAIL ovf_drain%0d: valid %b tdata %h want 1 %h", i, m_tvalid, m_tdata, {16'(i), 16'h0100 + 16'(i)});
            end
            tick();
        end
        checks++;
        if (m_tvalid !== 1'b0 || pending !== 3'd0 || overflow !== 1'b1) begin
            errors++; $display("FAIL ovf_end: valid %b pending %0d ovf %b want 0/0/1", m_tvalid, pending, overflow);
        end
    endtask

    task automatic test_full_pop();
        start_run(24'd0);
        checks++;
        if (overflow !== 1'b0) begin
            errors++; $display("FAIL fullpop_ovf_clr: got %b want 0", overflow);
        end
        m_tready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            trig_valid = 1'b1; trig_time = 16'h0200 + 16'(i);
            tick();
        end
        m_tready = 1'b1; trig_time = 16'h02FF;
        tick();
        trig_valid = 1'b0;
        checks++;
        if (pending !== 3'd4 || overflow !== 1'b0) begin
            errors++; $display("FAIL fullpop_accept: pending %0d overflow %b want 4/0", pending, overflow);
        end
        for (int i = 1; i < 5; i++) begin
            logic [15:0] t;
            t = (i == 4) ? 16'h02FF : 16'h0200 + 16'(i);
            checks++;
            if (m_tvalid !== 1'b1 || m_tdata !== {16'(i), t}) begin
                errors++; $display("FAIL fullpop_drain%0d: valid %b tdata %h want 1 %h", i, m_tvalid, m_tdata, {16'(i), t});
            end
            tick();
        end
    endtask

    task automatic test_stop_drain();
        int hs, pulses;
        logic bad;
        start_run(24'd3);
        m_tready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            trig_valid = 1'b1; trig_time = 16'h0300 + 16'(i);
            tick();
        end
        trig_valid = 1'b0;
        run_stop = 1'b1; m_tready = 1'b1;
        tick();  // stop and first handshake on this edge
        run_stop = 1'b0;
        checks++;
        if (running !== 1'b0 || pending !== 3'd1) begin
            errors++; $display("FAIL drain_enter: running %b pending %0d want 0/1", running, pending);
        end
        hs = 0; pulses = 0; bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            trig_valid = (i == 0); trig_time = 16'h03EE;
            if (m_tvalid === 1'b1) begin
                hs++;
                if (m_tdata !== {16'd1, 16'h0301}) bad = 1'b1;
            end
            tick();
            if (stop_done === 1'b1) pulses++;
        end
        trig_valid = 1'b0;
        checks++;
        if (hs !== 1 || bad !== 1'b0) begin
            errors++; $display("FAIL drain_emit: got %0d handshakes (bad data %b) want 1 of %h", hs, bad, {16'd1, 16'h0301});
        end
        checks++;
        if (pulses !== 1 || running !== 1'b0 || pending !== 3'd0) begin
            errors++; $display("FAIL drain_done: pulses %0d running %b pending %0d want 1/0/0", pulses, running, pending);
        end
    endtask

    task automatic test_restart();
        int n;
        start_run(24'd0);
        m_tready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            trig_valid = 1'b1; trig_time = 16'h0400 + 16'(i);
            tick();
        end
        run_rst = 1'b1; trig_time = 16'h04AA;
        tick();
        run_rst = 1'b0; trig_valid = 1'b0;
        checks++;
        if (m_tvalid !== 1'b0 || pending !== 3'd0 || running !== 1'b1) begin
            errors++; $display("FAIL restart_flush: valid %b pending %0d running %b want 0/0/1", m_tvalid, pending, running);
        end
        trig_valid = 1'b1; trig_time = 16'h04BB;
        tick();
        trig_valid = 1'b0;
        checks++;
        if (m_tvalid !== 1'b1 || m_tdata !== {16'd0, 16'h04BB}) begin
            errors++; $display("FAIL restart_evnum: valid %b tdata %h want 1 %h", m_tvalid, m_tdata, {16'd0, 16'h04BB});
        end
        m_tready = 1'b1;
        tick();
        run_stop = 1'b1;
        tick();
        run_stop = 1'b0;
        n = 0;
        while (stop_done !== 1'b1 && n < 20) begin
            tick(); n++;
        end
        checks++;
        if (stop_done !== 1'b1) begin
            errors++; $display("FAIL restart_stop: stop_done %b want 1 within 20 cycles", stop_done);
        end
        trig_valid = 1'b1; trig_time = 16'h04CC;
        tick();
        trig_valid = 1'b0;
        tick();
        checks++;
        if (m_tvalid !== 1'b0 || pending !== 3'd0 || running !== 1'b0) begin
            errors++; $display("FAIL restart_idle: valid %b pending %0d running %b want 0/0/0", m_tvalid, pending, running);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_holdoff();
        test_overflow();
        test_full_pop();
        test_stop_drain();
        test_restart();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pueo_trig_sched.md
Name: pueo_trig_sched

Overview:
Single-clock (aclk) trigger scheduler that sits between the trigger time source and the event-buffer readout.
- Queues trigger times and stamps each with an event number.
- Enforces a programmable read holdoff between successive readout issues.
- Gates acceptance with a run state machine (start/stop/drain).
- Generalises the fixed 16-bit trigger path and fixed holdoff capture into a parametrised, depth-buffered, back-pressured scheduler with overflow reporting.

Parameters:
TIME_BITS, 16, trigger time width
EVNUM_BITS, 16, event number width
DEPTH_LOG2, 4, log2 of pending-trigger queue depth (depth = 2^DEPTH_LOG2)
HOLDOFF_BITS, 24, read holdoff counter width
HOLDOFF_DEFAULT, 20475, holdoff value loaded at reset

Ports:
aclk_i  in  1  clock
aresetn_i  in  1  synchronous active-low reset
run_rst_i  in  1  run start/restart strobe
run_stop_i  in  1  run stop strobe
holdoff_i  in  HOLDOFF_BITS  read holdoff, captured on run_rst_i
trig_time_i  in  TIME_BITS  trigger time
trig_valid_i  in  1  trigger strobe, one trigger per cycle
m_tdata  out  EVNUM_BITS+TIME_BITS  {event number, trigger time}
m_tvalid  out  1  readout request valid
m_tready  in  1  readout consumer ready
running_o  out  1  high in RUN state
pending_o  out  DEPTH_LOG2+1  queue occupancy
overflow_o  out  1  sticky: trigger dropped on full queue
stop_done_o  out  1  one-cycle pulse when DRAIN completes

Behaviour:
- Reset (aresetn_i low at clock edge):
  - State IDLE; queue empty; event counter 0; holdoff timer 0; holdoff register = HOLDOFF_DEFAULT.
  - All outputs 0; m_tdata 0.
- States:
  - IDLE: triggers ignored (not queued, not counted). run_rst_i -> RUN.
  - RUN: triggers accepted. run_rst_i -> restart, remain RUN. run_stop_i -> DRAIN.
  - DRAIN: triggers ignored. Queue continues to drain. Queue empty AND holdoff timer 0 -> IDLE with stop_done_o high for exactly that cycle. run_rst_i -> RUN (restart).
- run_rst_i action, in any state:
  - Capture holdoff_i; flush queue; event counter to 0; holdoff timer to 0; overflow_o cleared; m_tvalid 0 next cycle.
  - A trigger on the same cycle is discarded.
  - run_rst_i and run_stop_i together: run_rst_i wins.
- Trigger accept (RUN only):
  - Entry {event counter, trig_time_i} written to the queue.
  - Event counter increments by 1 on every trigger seen in RUN, including dropped ones, so drops show as gaps.
  - Counter wraps modulo 2^EVNUM_BITS.
- Full queue:
  - Trigger accepted if a pop (m_tvalid & m_tready) occurs the same cycle.
  - Otherwise the trigger is dropped and overflow_o is set sticky.
- Output:
  - Registered show-ahead. m_tvalid = queue non-empty AND holdoff timer == 0.
  - Earliest m_tvalid is 1 cycle after accept into an empty queue with timer 0.
  - m_tdata stable while m_tvalid & !m_tready.
  - m_tvalid never deasserts without a handshake, except on run_rst_i or reset.
- Holdoff:
  - On handshake, timer loads the captured holdoff and decrements each cycle to 0.
  - Next m_tvalid no earlier than holdoff+1 cycles after the previous handshake.
  - Holdoff 0 allows back-to-back handshakes every cycle.
- pending_o: occupancy after this cycle's push/pop; range 0..2^DEPTH_LOG2.
- running_o is registered and tracks state == RUN.

Optional Feature:
- Macro PUEO_TRIG_SCHED_DROPCNT_EN.
- When defined: extra output drop_count_o, 16 bits. Counts dropped triggers, saturates at 16'hFFFF, cleared by run_rst_i and by reset. overflow_o is unchanged.
- When undefined: port absent, no counter logic.

Test Plan:
- Reset, run_rst_i with holdoff_i=0, 3 triggers at times 0x0010/0x0020/0x0030 on consecutive cycles, m_tready=1 -> three handshakes on consecutive cycles with m_tdata {0,0x0010},{1,0x0020},{2,0x0030}.
- holdoff_i=5, two triggers back-to-back, m_tready=1 -> second handshake exactly 6 cycles after the first.
- DEPTH_LOG2=2, m_tready=0, 6 triggers -> pending_o=4, overflow_o=1, then m_tready=1 drains event numbers 0,1,2,3; drop_count_o=2 when macro defined.
- Full queue with m_tready=1 and trigger on the same cycle as a pop -> trigger accepted, overflow_o stays 0.
- run_stop_i with 2 pending, holdoff=3 -> both emitted, stop_done_o pulses once after the final holdoff expires, running_o=0; a trigger during DRAIN is not emitted.
- run_rst_i mid-RUN with 3 pending plus a simultaneous trigger -> m_tvalid=0 next cycle, pending_o=0, next trigger gets event number 0; trigger in IDLE -> no output.
